mem_port_arbiter: RTL

- Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (loads and stores).
- Sits between the pipeline F/M stages and the memory macro. The pipeline stalls a stage while its request is pending without a done pulse.
- Only one transaction is in flight at a time. Data beats fetch by default.
- Includes a bus-timeout watchdog with a sticky error flag.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_arb_timeout.sv | 21 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int ABORT_RDATA = 0;
endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: bus watchdog counting cycles of an outstanding transaction; TIMEOUT=0 never expires
module mem_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 2);
  logic [CW-1:0] cnt_q, cnt_d;
  // expires during the TIMEOUT-th counted cycle so the abort lands on that cycle's edge
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CW'(TIMEOUT - 1));
  // next count: clear wins over increment
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages; ARB_FAIR_EN bounds fetch starvation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                m_req,
  output logic [DATA_W/8-1:0] m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ack,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                err_timeout
);
  localparam int BW = DATA_W / 8;
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              pick_data, expired, rd_cap, abort;
  logic [DATA_W-1:0] cap_data;

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == IDLE),
    .en_i      (state_q == ISSUE || state_q == WAIT),
    .expired_o (expired)
  );

`ifdef ARB_FAIR_EN
  localparam int FW = $clog2(FAIR_LIMIT + 1);
  logic [FW-1:0] fair_q, fair_d;
  assign pick_data = d_req && !(i_req && fair_q >= FW'(FAIR_LIMIT));
  // count data grants taken while fetch was waiting; any fetch grant or idle fetch resets it
  always_comb fair_d = (state_q == IDLE && (d_req || i_req)) ? ((pick_data && i_req) ? fair_q + 1'b1 : '0) : fair_q;
  // fairness counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) fair_q <= '0;
    else fair_q <= fair_d;
`else
  logic unused_fair;
  assign unused_fair = (FAIR_LIMIT != 0);
  assign pick_data   = d_req;
`endif

  // read data is taken on ack+rvalid in ISSUE or rvalid in WAIT; a real response beats the watchdog
  assign rd_cap   = m_rvalid && ((state_q == ISSUE && m_ack && we_q == '0) || state_q == WAIT);
  assign abort    = expired && !(state_q == ISSUE ? m_ack : m_rvalid);
  assign cap_data = abort ? DATA_W'(ABORT_RDATA) : m_rdata;

  // next-state, grant latching and read-data capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = (owner_q == OWN_I && (rd_cap || abort)) ? cap_data : i_rdata_q;
    d_rdata_d = (owner_q == OWN_D && (rd_cap || abort)) ? cap_data : d_rdata_q;
    err_d     = err_q || abort;
    case (state_q)
      IDLE: if (d_req || i_req) begin
        state_d = ISSUE;
        owner_d = pick_data ? OWN_D : OWN_I;
        addr_d  = pick_data ? d_addr : i_addr;
        we_d    = pick_data ? d_we : '0;
        wdata_d = pick_data ? d_wdata : '0;
      end
      ISSUE:   state_d = m_ack ? ((we_q != '0 || m_rvalid) ? DONE : WAIT) : expired ? DONE : ISSUE;
      WAIT:    state_d = (m_rvalid || expired) ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end

  assign m_req       = (state_q == ISSUE);
  assign m_we        = we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign i_done      = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done      = (state_q == DONE) && (owner_q == OWN_D);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
endmodule
